// File: rtl/axis_frame_checker_pkg.sv
// Shared types and constants for the AXI4-Stream frame checker.
// State encoding, LFSR seed/taps and the expected-word builder.
package axis_chk_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [7:0] LFSR_SEED = 8'hA5;
    // x^8 + x^6 + x^5 + x^4 -> bits 7,5,4,3
    localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

    // {fixed, count[cw-1:0]}; caller truncates to its data width
    function automatic logic [63:0] exp_word(
        input logic [63:0] fixed,
        input logic [63:0] cnt,
        input int          cw
    );
        return (fixed << cw) | (cnt & ((64'd1 << cw) - 64'd1));
    endfunction

endpackage

// File: rtl/axis_frame_checker_if.sv
// AXI4-Stream bundle between a stream source and a checker sink.
// Signals: tdata, tkeep, tlast, tvalid (source) and tready (sink).
interface axis_frame_checker_if #(
    parameter int DATA_WIDTH = 32
);
    logic [DATA_WIDTH-1:0]   tdata;
    logic [DATA_WIDTH/8-1:0] tkeep;
    logic                    tlast;
    logic                    tvalid;
    logic                    tready;

    modport master (output tdata, tkeep, tlast, tvalid, input tready);
    modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_ready_throttle.sv
// tready generator for stream sinks: steady or 8-bit LFSR throttled.
// Ports: clk, rst (sync, high), en (sink armed), ready (to tready).
module axis_ready_throttle
    import axis_chk_pkg::*;
#(
    parameter int READY_MODE = 0
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic ready
);

    logic [7:0] lfsr_q;

    always_ff @(posedge clk) begin
        if (rst)
            lfsr_q <= LFSR_SEED;
        else if (en)
            lfsr_q <= {lfsr_q[6:0], ^(lfsr_q & LFSR_TAPS)};
    end

    // mode 1 holds ready high on 3 of 4 LFSR states
    assign ready = en & ((READY_MODE == 0) | lfsr_q[0] | lfsr_q[1]);

endmodule

// File: rtl/axis_frame_checker.sv
// AXI4-Stream sink checking {FIXED_DATA, beat} frames from DMA MM2S.
// Ports: clk, rst, start, S_AXIS (slave), frames_ok, data/len error
// counters, busy, done, pass.
module axis_frame_checker
    import axis_chk_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int CNTR_WIDTH    = 4,
    parameter int FRAME_LENGTH  = 16,
    parameter int NUM_FRAMES    = 2,
    parameter logic [DATA_WIDTH-CNTR_WIDTH-1:0] FIXED_DATA = 28'h666A500,
    parameter int READY_MODE    = 0,
    parameter int ERR_CNT_WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     start,
    axis_frame_checker_if.slave      S_AXIS,
    output logic [15:0]              frames_ok,
    output logic [ERR_CNT_WIDTH-1:0] data_err_cnt,
    output logic [ERR_CNT_WIDTH-1:0] len_err_cnt,
    output logic                     busy,
    output logic                     done,
    output logic                     pass
);

    localparam logic [CNTR_WIDTH-1:0] LAST_BEAT = CNTR_WIDTH'(FRAME_LENGTH - 1);

    function automatic logic [ERR_CNT_WIDTH-1:0] sat_e(input logic [ERR_CNT_WIDTH-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    function automatic logic [15:0] sat_16(input logic [15:0] v);
        return (&v) ? v : v + 16'd1;
    endfunction

    state_t                  state_q, state_n;
    logic [CNTR_WIDTH-1:0]   beat_q, beat_n;
    logic                    bad_q, bad_n;
    logic                    late_q, late_n;
    logic [15:0]             fcnt_q, fcnt_n;
    logic [15:0]             fok_n;
    logic [ERR_CNT_WIDTH-1:0] derr_n, lerr_n;
    logic                    pass_q, pass_n;
    logic                    tready;
    logic                    hs, beat_bad, at_last;
    logic [DATA_WIDTH-1:0]   exp_data;

    axis_ready_throttle #(
        .READY_MODE (READY_MODE)
    ) u_throttle (
        .clk   (clk),
        .rst   (rst),
        .en    (state_q == RUN),
        .ready (tready)
    );

    assign S_AXIS.tready = tready;

    assign exp_data = DATA_WIDTH'(exp_word(64'(FIXED_DATA), 64'(beat_q), CNTR_WIDTH));
    assign hs       = (state_q == RUN) & S_AXIS.tvalid & tready;
    assign beat_bad = (S_AXIS.tdata != exp_data) | (S_AXIS.tkeep != '1);
    assign at_last  = (beat_q == LAST_BEAT);

    always_ff @(posedge clk) begin
        if (rst)
            state_q <= IDLE;
        else
            state_q <= state_n;
    end

    always_comb begin
        state_n = state_q;
        beat_n  = beat_q;
        bad_n   = bad_q;
        late_n  = late_q;
        fcnt_n  = fcnt_q;
        fok_n   = frames_ok;
        derr_n  = data_err_cnt;
        lerr_n  = len_err_cnt;
        pass_n  = pass_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_n = RUN;
                    beat_n  = '0;
                    bad_n   = 1'b0;
                    late_n  = 1'b0;
                    fcnt_n  = '0;
                    fok_n   = '0;
                    derr_n  = '0;
                    lerr_n  = '0;
                    pass_n  = 1'b0;
                end
            end
            RUN: begin
                if (hs) begin
                    if (beat_bad)
                        derr_n = sat_e(data_err_cnt);
                    if (S_AXIS.tlast) begin
                        // a late frame already paid its length error
                        if (!late_q && !at_last)
                            lerr_n = sat_e(len_err_cnt);
                        if (!bad_q && !beat_bad && !late_q && at_last)
                            fok_n = sat_16(frames_ok);
                        beat_n = '0;
                        bad_n  = 1'b0;
                        late_n = 1'b0;
                        fcnt_n = fcnt_q + 16'd1;
                        if (fcnt_n == 16'(NUM_FRAMES)) begin
                            state_n = DONE;
                            pass_n  = (fok_n == 16'(NUM_FRAMES))
                                    && (derr_n == '0) && (lerr_n == '0);
                        end
                    end else begin
                        if (at_last && !late_q) begin
                            lerr_n = sat_e(len_err_cnt);
                            late_n = 1'b1;
                        end
                        bad_n  = bad_q | beat_bad;
                        beat_n = beat_q + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beat_q       <= '0;
            bad_q        <= 1'b0;
            late_q       <= 1'b0;
            fcnt_q       <= '0;
            frames_ok    <= '0;
            data_err_cnt <= '0;
            len_err_cnt  <= '0;
            pass_q       <= 1'b0;
        end else begin
            beat_q       <= beat_n;
            bad_q        <= bad_n;
            late_q       <= late_n;
            fcnt_q       <= fcnt_n;
            frames_ok    <= fok_n;
            data_err_cnt <= derr_n;
            len_err_cnt  <= lerr_n;
            pass_q       <= pass_n;
        end
    end

    assign busy = (state_q == RUN);
    assign done = (state_q == DONE);
    assign pass = pass_q;

endmodule

// File: tb/tb_axis_frame_checker.sv
// Bench for axis_frame_checker: steady and throttled sinks driven
// from one stream source, checked against a frame-level model.
module tb_axis_frame_checker;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        sel = 1'b0;
    logic [31:0] tdata = '0;
    logic [3:0]  tkeep = '0;
    logic        tlast = 1'b0;
    logic        tvalid = 1'b0;

    int cmp = 0;
    int errs = 0;
    int stalls = 0;
    int m_ok, m_derr, m_lerr;

    axis_frame_checker_if #(.DATA_WIDTH(32)) ax0 ();
    axis_frame_checker_if #(.DATA_WIDTH(32)) ax1 ();

    logic [15:0] fok0, fok1, derr0, derr1, lerr0, lerr1;
    logic        busy0, busy1, done0, done1, pass0, pass1;
    logic        start0, start1;

    assign ax0.tdata  = tdata;
    assign ax0.tkeep  = tkeep;
    assign ax0.tlast  = tlast;
    assign ax0.tvalid = tvalid & ~sel;
    assign ax1.tdata  = tdata;
    assign ax1.tkeep  = tkeep;
    assign ax1.tlast  = tlast;
    assign ax1.tvalid = tvalid & sel;
    assign start0     = start & ~sel;
    assign start1     = start & sel;

    logic        tready, busy, done, pass;
    logic [15:0] fok, derr, lerr;
    assign tready = sel ? ax1.tready : ax0.tready;
    assign fok    = sel ? fok1  : fok0;
    assign derr   = sel ? derr1 : derr0;
    assign lerr   = sel ? lerr1 : lerr0;
    assign busy   = sel ? busy1 : busy0;
    assign done   = sel ? done1 : done0;
    assign pass   = sel ? pass1 : pass0;

    axis_frame_checker #(.READY_MODE(0)) u_dut0 (
        .clk (clk), .rst (rst), .start (start0), .S_AXIS (ax0),
        .frames_ok (fok0), .data_err_cnt (derr0), .len_err_cnt (lerr0),
        .busy (busy0), .done (done0), .pass (pass0)
    );

    axis_frame_checker #(.READY_MODE(1)) u_dut1 (
        .clk (clk), .rst (rst), .start (start1), .S_AXIS (ax1),
        .frames_ok (fok1), .data_err_cnt (derr1), .len_err_cnt (lerr1),
        .busy (busy1), .done (done1), .pass (pass1)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] expw(input int i);
        return 32'h666A5000 | 32'(i % 16);
    endfunction

    // frame-level reference: data errors per bad beat, length error
    // when the frame is not exactly 16 beats, good when neither
    task automatic model_frame(input int len, input int bb,
                               input logic [31:0] bd, input logic [3:0] bk);
        bit fbad = 0;
        for (int i = 0; i < len; i++) begin
            logic [31:0] w = (i == bb) ? bd : expw(i);
            logic [3:0]  k = (i == bb) ? bk : 4'hF;
            if (w != expw(i) || k != 4'hF) begin
                m_derr++;
                fbad = 1;
            end
        end
        if (len != 16) begin
            m_lerr++;
            fbad = 1;
        end
        if (!fbad) m_ok++;
    endtask

    task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l);
        int n = 0;
        tdata  = d;
        tkeep  = k;
        tlast  = l;
        tvalid = 1'b1;
        forever begin
            @(negedge clk);
            if (tready) begin
                @(posedge clk);
                #1;
                break;
            end
            stalls++;
            n++;
            if (n > 200) begin
                cmp++; errs++;
                $display("FAIL handshake_timeout tready stuck low (got 0, need 1)");
                break;
            end
        end
    endtask

    task automatic send_frame(input int len, input int bb, input logic [31:0] bd,
                              input logic [3:0] bk, input bit gaps, input bit do_last);
        for (int i = 0; i < len; i++) begin
            if (gaps && ($urandom % 4 == 0)) begin
                tvalid = 1'b0;
                @(posedge clk);
                #1;
            end
            send_beat((i == bb) ? bd : expw(i), (i == bb) ? bk : 4'hF,
                      do_last && (i == len - 1));
        end
        tvalid = 1'b0;
        tlast  = 1'b0;
    endtask

    task automatic do_start();
        m_ok = 0; m_derr = 0; m_lerr = 0;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        cmp++; if (tready !== 1'b0) begin errs++; $display("FAIL reset_tready got %b need 0", tready); end
        cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL reset_busy got %b need 0", busy); end
        cmp++; if (done !== 1'b0) begin errs++; $display("FAIL reset_done got %b need 0", done); end
        cmp++; if (pass !== 1'b0) begin errs++; $display("FAIL reset_pass got %b need 0", pass); end
        cmp++; if (fok !== 16'd0) begin errs++; $display("FAIL reset_frames_ok got %0d need 0", fok); end
        cmp++; if (derr !== 16'd0) begin errs++; $display("FAIL reset_data_err got %0d need 0", derr); end
        cmp++; if (lerr !== 16'd0) begin errs++; $display("FAIL reset_len_err got %0d need 0", lerr); end
        rst = 1'b0;
        @(posedge clk);
        #1;
        cmp++; if (tready !== 1'b0) begin errs++; $display("FAIL idle_tready got %b need 0", tready); end
    endtask

    task automatic test_clean();
        do_start();
        cmp++; if (busy !== 1'b1) begin errs++; $display("FAIL clean_busy got %b need 1", busy); end
        for (int f = 0; f < 2; f++) begin
            model_frame(16, -1, 0, 0);
            send_frame(16, -1, 0, 0, 0, 1);
        end
        cmp++; if (done !== 1'b1) begin errs++; $display("FAIL clean_done got %b need 1", done); end
        cmp++; if (tready !== 1'b0) begin errs++; $display("FAIL clean_tready_drop got %b need 0", tready); end
        cmp++; if (fok !== 16'(m_ok)) begin errs++; $display("FAIL clean_frames_ok got %0d need %0d", fok, m_ok); end
        cmp++; if (derr !== 16'(m_derr)) begin errs++; $display("FAIL clean_data_err got %0d need %0d", derr, m_derr); end
        cmp++; if (pass !== 1'b1) begin errs++; $display("FAIL clean_pass got %b need 1", pass); end
    endtask

    task automatic test_data_err();
        do_start();
        model_frame(16, 5, 32'h666A5F05, 4'hF);
        send_frame(16, 5, 32'h666A5F05, 4'hF, 0, 1);
        model_frame(16, -1, 0, 0);
        send_frame(16, -1, 0, 0, 0, 1);
        cmp++; if (derr !== 16'(m_derr)) begin errs++; $display("FAIL derr_count got %0d need %0d", derr, m_derr); end
        cmp++; if (fok !== 16'(m_ok)) begin errs++; $display("FAIL derr_frames_ok got %0d need %0d", fok, m_ok); end
        cmp++; if (done !== 1'b1) begin errs++; $display("FAIL derr_done got %b need 1", done); end
        cmp++; if (pass !== 1'b0) begin errs++; $display("FAIL derr_pass got %b need 0", pass); end
    endtask

    task automatic test_early();
        do_start();
        model_frame(10, -1, 0, 0);
        send_frame(10, -1, 0, 0, 0, 1);
        cmp++; if (done !== 1'b0) begin errs++; $display("FAIL early_done_too_soon got %b need 0", done); end
        cmp++; if (lerr !== 16'(m_lerr)) begin errs++; $display("FAIL early_len_err got %0d need %0d", lerr, m_lerr); end
        model_frame(16, -1, 0, 0);
        send_frame(16, -1, 0, 0, 0, 1);
        cmp++; if (done !== 1'b1) begin errs++; $display("FAIL early_done got %b need 1", done); end
        cmp++; if (fok !== 16'(m_ok)) begin errs++; $display("FAIL early_frames_ok got %0d need %0d", fok, m_ok); end
        cmp++; if (pass !== 1'b0) begin errs++; $display("FAIL early_pass got %b need 0", pass); end
    endtask

    task automatic test_late();
        do_start();
        model_frame(18, -1, 0, 0);
        send_frame(18, -1, 0, 0, 0, 1);
        cmp++; if (busy !== 1'b1) begin errs++; $display("FAIL late_busy got %b need 1", busy); end
        model_frame(16, -1, 0, 0);
        send_frame(16, -1, 0, 0, 0, 1);
        cmp++; if (lerr !== 16'(m_lerr)) begin errs++; $display("FAIL late_len_err got %0d need %0d", lerr, m_lerr); end
        cmp++; if (derr !== 16'(m_derr)) begin errs++; $display("FAIL late_data_err got %0d need %0d", derr, m_derr); end
        cmp++; if (fok !== 16'(m_ok)) begin errs++; $display("FAIL late_frames_ok got %0d need %0d", fok, m_ok); end
        cmp++; if (done !== 1'b1) begin errs++; $display("FAIL late_done got %b need 1", done); end
    endtask

    task automatic test_throttle();
        sel = 1'b1;
        do_start();
        stalls = 0;
        for (int f = 0; f < 2; f++) begin
            model_frame(16, -1, 0, 0);
            send_frame(16, -1, 0, 0, 0, 1);
        end
        cmp++; if (stalls == 0) begin errs++; $display("FAIL thr_toggle stall cycles got 0 need >0"); end
        cmp++; if (fok !== 16'(m_ok)) begin errs++; $display("FAIL thr_frames_ok got %0d need %0d", fok, m_ok); end
        cmp++; if (derr !== 16'(m_derr)) begin errs++; $display("FAIL thr_data_err got %0d need %0d", derr, m_derr); end
        cmp++; if (pass !== 1'b1) begin errs++; $display("FAIL thr_pass got %b need 1", pass); end
        cmp++; if (tready !== 1'b0) begin errs++; $display("FAIL thr_tready_drop got %b need 0", tready); end
        sel = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_start();
        send_frame(16, -1, 0, 0, 0, 1);
        send_frame(7, -1, 0, 0, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cmp++; if (busy !== 1'b0) begin errs++; $display("FAIL rmid_busy got %b need 0", busy); end
        cmp++; if (fok !== 16'd0) begin errs++; $display("FAIL rmid_frames_ok got %0d need 0", fok); end
        cmp++; if (tready !== 1'b0) begin errs++; $display("FAIL rmid_tready got %b need 0", tready); end
        do_start();
        for (int f = 0; f < 2; f++) begin
            model_frame(16, -1, 0, 0);
            send_frame(16, -1, 0, 0, 0, 1);
        end
        cmp++; if (fok !== 16'(m_ok)) begin errs++; $display("FAIL rmid_after_frames_ok got %0d need %0d", fok, m_ok); end
        cmp++; if (pass !== 1'b1) begin errs++; $display("FAIL rmid_after_pass got %b need 1", pass); end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            bit exp_pass;
            sel = 1'($urandom % 2);
            do_start();
            for (int f = 0; f < 2; f++) begin
                int kind = $urandom % 4;
                int len = 16;
                int bb = -1;
                logic [31:0] bd = '0;
                logic [3:0]  bk = 4'hF;
                if (kind == 1) begin
                    bb = $urandom_range(0, 15);
                    if ($urandom % 2) bd = expw(bb) ^ (32'd1 << $urandom_range(0, 31));
                    else begin bd = expw(bb); bk = 4'($urandom_range(0, 14)); end
                end
                if (kind == 2) len = $urandom_range(2, 15);
                if (kind == 3) len = $urandom_range(17, 20);
                model_frame(len, bb, bd, bk);
                send_frame(len, bb, bd, bk, !sel, 1);
            end
            exp_pass = (m_ok == 2) && (m_derr == 0) && (m_lerr == 0);
            cmp++; if (fok !== 16'(m_ok)) begin errs++; $display("FAIL rnd%0d_frames_ok got %0d need %0d", it, fok, m_ok); end
            cmp++; if (derr !== 16'(m_derr)) begin errs++; $display("FAIL rnd%0d_data_err got %0d need %0d", it, derr, m_derr); end
            cmp++; if (lerr !== 16'(m_lerr)) begin errs++; $display("FAIL rnd%0d_len_err got %0d need %0d", it, lerr, m_lerr); end
            cmp++; if (done !== 1'b1) begin errs++; $display("FAIL rnd%0d_done got %b need 1", it, done); end
            cmp++; if (pass !== exp_pass) begin errs++; $display("FAIL rnd%0d_pass got %b need %b", it, pass, exp_pass); end
        end
        sel = 1'b0;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_data_err();
        test_early();
        test_late();
        test_throttle();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end

endmodule

// File: doc/axis_frame_checker.md
Name: axis_frame_checker

Overview:
- Synthesizable AXI4-Stream sink placed directly downstream of the DMA MM2S stream port.
- Consumes frames read back from memory and checks each beat against the pattern the stream stimulus writes: {FIXED_DATA, beat counter}.
- Counts good frames and data/length/keep errors, and raises done/pass once NUM_FRAMES frames are received.
- Configurable tready throttling exercises DMA backpressure.

Parameters:
- DATA_WIDTH, 32, tdata width; must equal (DATA_WIDTH-CNTR_WIDTH) fixed bits + CNTR_WIDTH.
- CNTR_WIDTH, 4, width of per-frame beat counter in tdata LSBs.
- FRAME_LENGTH, 16, beats per frame; 2..2**CNTR_WIDTH.
- NUM_FRAMES, 2, frames expected before done.
- FIXED_DATA, 28'h666A500, expected tdata[DATA_WIDTH-1:CNTR_WIDTH].
- READY_MODE, 0, 0 = tready always high when armed; 1 = 8-bit LFSR throttle (tready = lfsr[0] | lfsr[1]).
- ERR_CNT_WIDTH, 16, width of error counters (saturating).

Ports:
- clk  in  1  stream clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  one-cycle pulse; arms checker, clears counters.
- S_AXIS_tdata  in  DATA_WIDTH  stream data.
- S_AXIS_tkeep  in  DATA_WIDTH/8  byte enables; all-ones required.
- S_AXIS_tlast  in  1  end of frame.
- S_AXIS_tvalid  in  1  source valid.
- S_AXIS_tready  out  1  sink ready.
- frames_ok  out  16  frames received with no error.
- data_err_cnt  out  ERR_CNT_WIDTH  beats with tdata or tkeep mismatch.
- len_err_cnt  out  ERR_CNT_WIDTH  frames ending early (tlast before beat FRAME_LENGTH-1) or late (no tlast at beat FRAME_LENGTH-1).
- busy  out  1  high in RUN.
- done  out  1  level; high in DONE.
- pass  out  1  valid when done: frames_ok==NUM_FRAMES and both error counts zero.

Behaviour:
- Reset: state IDLE; tready=0; all counters 0; busy=0, done=0, pass=0; beat counter 0; LFSR=8'hA5 (nonzero seed).
- Transfer occurs on a clk edge with tvalid & tready. Data is sampled only then; tvalid without tready is ignored.
- States:
  - IDLE: tready=0. start -> RUN, clearing all counters.
  - RUN: tready per READY_MODE; LFSR advances every cycle in RUN (taps 8,6,5,4). After NUM_FRAMES frames have closed (good or bad) -> DONE.
  - DONE: tready=0, done=1, pass registered. start -> RUN with counters cleared. start is ignored in RUN.
- Per-beat check, beat counter b:
  - Expected tdata = {FIXED_DATA, b[CNTR_WIDTH-1:0]}.
  - Mismatch, or tkeep != all-ones: data_err_cnt+1 (at most once per beat), and the frame is marked bad.
- Frame closing:
  - tlast at b==FRAME_LENGTH-1: frame closes; b->0; frames_ok+1 if not bad.
  - tlast at b<FRAME_LENGTH-1: early; len_err_cnt+1; frame closes bad; b->0.
  - No tlast at b==FRAME_LENGTH-1: late; len_err_cnt+1, counted once per frame. Checker keeps consuming, incrementing b (wraps mod 2**CNTR_WIDTH) until tlast, which then closes the bad frame.
- Frame count: a frame counter of closed frames drives the DONE transition. The last handshake and the state change occur on the same edge; tready drops the next cycle.
- Error counters saturate at all-ones. frames_ok saturates at 16'hFFFF.
- Simultaneous start and handshake in IDLE/DONE cannot occur (tready=0).
- rst mid-frame returns to IDLE with all outputs at reset values; the partial frame is discarded.
- Latency: counters update one cycle after the transfer edge. pass is valid on the same cycle done rises.

Decomposition:
- Package axis_chk_pkg: state enum (IDLE, RUN, DONE), LFSR seed and tap constants, expected-word helper function {fixed, count}.
- One sub-module: axis_ready_throttle (LFSR-based tready generator, enable input, READY_MODE parameter). Reusable by other sink checkers.

Test Plan:
- Default params, READY_MODE=0, 2 clean 16-beat frames 0x666A5000..0x666A500F, then start -> frames_ok=2, errors 0, done=1, pass=1, tready low after final tlast.
- Beat 5 of frame 0 sent as 0x666A5F05 -> data_err_cnt=1, frames_ok=1, pass=0.
- Frame 0 tlast at beat 9 -> len_err_cnt=1; frame 1 clean -> frames_ok=1, done after 2 closures.
- Frame 0 runs 18 beats with tlast on beat 17 -> len_err_cnt=1; beats 16/17 expected low nibble 0/1 -> no data error; done after frame 1.
- READY_MODE=1 with tvalid held high -> tready toggles and no beat is lost or duplicated; frames_ok=2, pass=1; tdata changes only after handshake.
- rst asserted at beat 7 of frame 1 -> all outputs zero next cycle; new start plus 2 clean frames -> pass=1.
